// File: rtl/avalon_st_error_adapter_pipe.sv
// Avalon-ST error-width adapter with a registered 2-entry skid stage and optional EOP error accumulation.
// Define ERR_ADAPT_STATS_EN to add the errored-packet counter (stats_clr / err_pkt_cnt).
module avalon_st_error_adapter_pipe #(
  parameter int DATA_W     = 64,
  parameter int EMPTY_W    = 3,
  parameter int IN_ERR_W   = 1,
  parameter int OUT_ERR_W  = 2,
  parameter int STICKY_EOP = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [IN_ERR_W-1:0]  in_error,
  input  logic                 in_startofpacket,
  input  logic                 in_endofpacket,
  input  logic [EMPTY_W-1:0]   in_empty,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [OUT_ERR_W-1:0] out_error,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [EMPTY_W-1:0]   out_empty
`ifdef ERR_ADAPT_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [CNT_W-1:0]     err_pkt_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [OUT_ERR_W-1:0] err;
    logic                 sop;
    logic                 eop;
    logic [EMPTY_W-1:0]   empty;
  } beat_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t state_q, state_d;
  logic   in_ready_q, out_valid_q;
  logic   accept, pop;
  logic   ld_out_in, ld_out_skid, ld_skid;
  beat_t  in_beat, out_q, skid_q;
  logic [OUT_ERR_W-1:0] map_err, beat_err;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // Error width mapping; narrowing folds all upper input bits into the top output bit.
  if (OUT_ERR_W >= IN_ERR_W) begin : g_widen
    assign map_err = OUT_ERR_W'(in_error);
  end else if (OUT_ERR_W == 1) begin : g_narrow1
    assign map_err = |in_error;
  end else begin : g_narrow
    assign map_err = {|(in_error >> (OUT_ERR_W-1)), in_error[OUT_ERR_W-2:0]};
  end

  if (STICKY_EOP != 0) begin : g_sticky
    logic [OUT_ERR_W-1:0] sticky_q, sticky_d, base;
    always_comb begin
      base     = in_startofpacket ? '0 : sticky_q;
      beat_err = in_endofpacket ? (base | map_err) : map_err;
      sticky_d = sticky_q;
      if (accept) sticky_d = in_endofpacket ? '0 : (base | map_err);
    end
    always_ff @(posedge clk) begin
      if (!reset_n) sticky_q <= '0;
      else          sticky_q <= sticky_d;
    end
  end else begin : g_pass
    assign beat_err = map_err;
  end

  assign in_beat = '{data: in_data, err: beat_err, sop: in_startofpacket,
                     eop: in_endofpacket, empty: in_empty};

  // State register; ready/valid are flopped from the next state so neither is combinational.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (accept && !pop)      state_d = S_FULL;
        else if (pop && !accept) state_d = S_EMPTY;
      end
      S_FULL:  if (pop) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state_q)
      S_EMPTY: ld_out_in = accept;
      S_ONE: begin
        ld_out_in = accept & pop;
        ld_skid   = accept & ~pop;
      end
      S_FULL:  ld_out_skid = pop;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out_in)        out_q <= in_beat;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid)          skid_q <= in_beat;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_data          = out_q.data;
  assign out_error         = out_q.err;
  assign out_startofpacket = out_q.sop;
  assign out_endofpacket   = out_q.eop;
  assign out_empty         = out_q.empty;

`ifdef ERR_ADAPT_STATS_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n)       cnt_q <= '0;
    else if (stats_clr) cnt_q <= '0;
    else if (pop && out_q.eop && (|out_q.err) && (cnt_q != '1))
      cnt_q <= cnt_q + 1'b1;
  end
  assign err_pkt_cnt = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_avalon_st_error_adapter_pipe.sv
// Scoreboard bench: the driver pushes hand-computed expected beats on acceptance, a monitor pops on each output handshake.
module tb_avalon_st_error_adapter_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT: defaults, sticky EOP
  logic        in_ready, in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [0:0]  in_error = '0;
  logic        in_sop = 1'b0, in_eop = 1'b0;
  logic [2:0]  in_empty = '0;
  logic        out_ready = 1'b1, out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_error;
  logic        out_sop, out_eop;
  logic [2:0]  out_empty;
`ifdef ERR_ADAPT_STATS_EN
  logic        stats_clr = 1'b0;
  logic [1:0]  err_pkt_cnt;
  logic        n_stats_clr = 1'b0;
  logic [15:0] n_cnt;
`endif

  // narrowing DUT: 4 -> 2 error bits, no sticky
  logic       n_in_ready, n_in_valid = 1'b0;
  logic [7:0] n_in_data = '0;
  logic [3:0] n_in_error = '0;
  logic       n_out_valid;
  logic [7:0] n_out_data;
  logic [1:0] n_out_error;
  logic       n_out_sop, n_out_eop;
  logic [0:0] n_out_empty;

  avalon_st_error_adapter_pipe #(.DATA_W(64), .EMPTY_W(3), .IN_ERR_W(1), .OUT_ERR_W(2),
                                 .STICKY_EOP(1), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_ready(in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_error(in_error), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .in_empty(in_empty), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty)
`ifdef ERR_ADAPT_STATS_EN
    , .stats_clr(stats_clr), .err_pkt_cnt(err_pkt_cnt)
`endif
  );

  avalon_st_error_adapter_pipe #(.DATA_W(8), .EMPTY_W(1), .IN_ERR_W(4), .OUT_ERR_W(2),
                                 .STICKY_EOP(0), .CNT_W(16)) dut_n (
    .clk(clk), .reset_n(reset_n), .in_ready(n_in_ready), .in_valid(n_in_valid),
    .in_data(n_in_data), .in_error(n_in_error), .in_startofpacket(1'b1),
    .in_endofpacket(1'b1), .in_empty(1'b0), .out_ready(1'b1),
    .out_valid(n_out_valid), .out_data(n_out_data), .out_error(n_out_error),
    .out_startofpacket(n_out_sop), .out_endofpacket(n_out_eop), .out_empty(n_out_empty)
`ifdef ERR_ADAPT_STATS_EN
    , .stats_clr(n_stats_clr), .err_pkt_cnt(n_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  err;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("out_data",  out_data,  mon_e.data);
        chk("out_error", {62'd0, out_error}, {62'd0, mon_e.err});
        chk("out_sop",   {63'd0, out_sop},   {63'd0, mon_e.sop});
        chk("out_eop",   {63'd0, out_eop},   {63'd0, mon_e.eop});
        chk("out_empty", {61'd0, out_empty}, {61'd0, mon_e.empty});
      end
    end
  end

  // Hold a beat until accepted; waits reports the stalled cycles.
  task automatic send(input logic [63:0] d, input logic err, input logic sop, input logic eop,
                      input logic [2:0] emp, input logic [1:0] xerr, output int waits);
    in_valid = 1'b1; in_data = d; in_error = err; in_sop = sop; in_eop = eop; in_empty = emp;
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(exp_t'{d, xerr, sop, eop, emp});
        @(posedge clk); #1;
        return;
      end
      waits++;
      @(posedge clk); #1;
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sbq.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_queue_empty", 64'(sbq.size()), 64'd0);
  endtask

  int w;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
    chk("rst_out_data",  out_data, 64'd0);
    chk("rst_out_error", {62'd0, out_error}, 64'd0);
`ifdef ERR_ADAPT_STATS_EN
    chk("rst_cnt", {62'd0, err_pkt_cnt}, 64'd0);
`endif
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // streaming: 8 beats, one per cycle, each visible the cycle after acceptance
    for (int k = 0; k < 8; k++) begin
      send(64'(k), 1'b0, k == 0, k == 7, 3'(k), 2'b00, w);
      chk("stream_no_stall", 64'(w), 64'd0);
      chk("stream_latency", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    drain();

    // backpressure: downstream stalls 5 cycles, skid absorbs 2 beats
    fork
      begin
        for (int k = 0; k < 6; k++) send(64'h100 + 64'(k), 1'b0, k == 0, k == 5, 3'd0, 2'b00, w);
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid",    {63'd0, out_valid}, 64'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // sticky: error on beat 1 surfaces again on the EOP
    send(64'h200, 1'b0, 1'b1, 1'b0, 3'd0, 2'b00, w);
    send(64'h201, 1'b1, 1'b0, 1'b0, 3'd0, 2'b01, w);
    send(64'h202, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, w);
    send(64'h203, 1'b0, 1'b0, 1'b1, 3'd5, 2'b01, w);
    for (int k = 0; k < 4; k++) send(64'h210 + 64'(k), 1'b0, k == 0, k == 3, 3'd0, 2'b00, w);
    // single-beat errored packet, then a clean packet
    send(64'h220, 1'b1, 1'b1, 1'b1, 3'd2, 2'b01, w);
    send(64'h221, 1'b0, 1'b1, 1'b1, 3'd0, 2'b00, w);
    // SOP without preceding EOP drops the stale error
    send(64'h230, 1'b1, 1'b1, 1'b0, 3'd0, 2'b01, w);
    send(64'h231, 1'b0, 1'b1, 1'b0, 3'd0, 2'b00, w);
    send(64'h232, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, w);
    in_valid = 1'b0;
    drain();

    // narrowing 4 -> 2 bits
    begin
      logic [3:0] nv [4];
      logic [1:0] ne [4];
      nv = '{4'b0100, 4'b0001, 4'b1000, 4'b0011};
      ne = '{2'b10,   2'b01,   2'b10,   2'b11};
      for (int k = 0; k < 4; k++) begin
        n_in_valid = 1'b1; n_in_error = nv[k]; n_in_data = 8'(k);
        @(negedge clk);
        chk("narrow_in_ready", {63'd0, n_in_ready}, 64'd1);
        @(posedge clk); #1 n_in_valid = 1'b0;
        chk("narrow_out_valid", {63'd0, n_out_valid}, 64'd1);
        chk("narrow_out_error", {62'd0, n_out_error}, {62'd0, ne[k]});
        @(posedge clk); #1;
      end
    end

    // reset with the skid full and sticky armed
    out_ready = 1'b0;
    send(64'h300, 1'b1, 1'b1, 1'b0, 3'd0, 2'b01, w);
    send(64'h301, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, w);
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready",  {63'd0, in_ready},  64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(64'h310, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, w);
    send(64'h311, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, w);
    in_valid = 1'b0;
    drain();

`ifdef ERR_ADAPT_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    chk("stats_clr", {62'd0, err_pkt_cnt}, 64'd0);
    for (int k = 0; k < 5; k++) send(64'h400 + 64'(k), 1'b1, 1'b1, 1'b1, 3'd0, 2'b01, w);
    in_valid = 1'b0;
    drain();
    chk("stats_saturate", {62'd0, err_pkt_cnt}, 64'd3);
    stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    chk("stats_clr2", {62'd0, err_pkt_cnt}, 64'd0);
    send(64'h410, 1'b1, 1'b1, 1'b1, 3'd0, 2'b01, w);
    in_valid = 1'b0;
    stats_clr = 1'b1;
    @(posedge clk); #1 stats_clr = 1'b0;
    chk("stats_clr_wins", {62'd0, err_pkt_cnt}, 64'd0);
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
